tag_lookup_ctrl: RTL

Lookup/allocation controller that reads the bank tag store each request, compares the tags, and writes new tags back on a miss. It drives the tag memory's read-address port and its single-tag write port. It consumes the registered 8-way tag vector and valid bits one cycle after the read address. Results go downstream over a valid/ready handshake: hit/miss, way, and evicted tag for writeback.

---
 rtl/tag_cache_pkg.sv | 24 ++
 rtl/way_select.sv | 35 +++
 rtl/tag_lookup_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/tag_cache_pkg.sv
// Shared constants, FSM state type and tag-vector helper for the tag lookup controller.
package tag_cache_pkg;

    localparam int DEF_TAG_W    = 10;
    localparam int DEF_SET_W    = 5;
    localparam int DEF_N_WAY    = 3;
    localparam int DEF_LG_BANKS = 1;
    localparam int BSW          = DEF_SET_W - DEF_LG_BANKS;
    localparam int NUM_WAYS     = 1 << DEF_N_WAY;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESP
    } state_t;

    function automatic logic [DEF_TAG_W-1:0] tag_slice(
        input logic [NUM_WAYS*DEF_TAG_W-1:0] tags,
        input logic [DEF_N_WAY-1:0]          way
    );
        return tags[way*DEF_TAG_W +: DEF_TAG_W];
    endfunction

endpackage

// File: rtl/way_select.sv
// Combinational hit/victim selection: lowest matching way wins, lowest free way
// is preferred for allocation, otherwise the round-robin pointer picks the victim.
module way_select
    import tag_cache_pkg::*;
#(
    parameter int N_WAY_LG = DEF_N_WAY
) (
    input  logic [(1<<N_WAY_LG)-1:0] valid_bits,
    input  logic [(1<<N_WAY_LG)-1:0] match_vec,
    input  logic [N_WAY_LG-1:0]      rr_ptr,
    output logic                     hit,
    output logic [N_WAY_LG-1:0]      hit_way,
    output logic [N_WAY_LG-1:0]      victim_way,
    output logic                     evict
);

    localparam int WAYS = 1 << N_WAY_LG;

    // Scanning downward lets the lowest index overwrite any higher candidate.
    always_comb begin
        hit        = |match_vec;
        hit_way    = '0;
        victim_way = rr_ptr;
        evict      = !(|match_vec) && (&valid_bits);
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                hit_way = N_WAY_LG'(i);
            end
            if (!valid_bits[i]) begin
                victim_way = N_WAY_LG'(i);
            end
        end
    end

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Tag lookup/allocation controller: reads a set, compares all ways, writes the
// new tag on a miss and reports hit/way/eviction over a valid/ready handshake.
module tag_lookup_ctrl
    import tag_cache_pkg::*;
#(
    parameter int TAG_ADDR_WDTH = DEF_TAG_W,
    parameter int SET_ADDR_WDTH = DEF_SET_W,
    parameter int C_N_WAY       = DEF_N_WAY,
    parameter int C_LG_BANKS    = DEF_LG_BANKS
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic [SET_ADDR_WDTH-C_LG_BANKS-1:0]           req_set,
    input  logic [TAG_ADDR_WDTH-1:0]                      req_tag,
    output logic [SET_ADDR_WDTH-C_LG_BANKS-1:0]           tag_r_addr,
    input  logic [(1<<C_N_WAY)*TAG_ADDR_WDTH-1:0]         tag_r_data,
    input  logic [(1<<C_N_WAY)-1:0]                       tag_valid_bits,
    output logic                                          tag_w_en,
    output logic [SET_ADDR_WDTH-C_LG_BANKS+C_N_WAY-1:0]   tag_w_addr,
    output logic [TAG_ADDR_WDTH-1:0]                      tag_w_data,
    output logic                                          resp_valid,
    input  logic                                          resp_ready,
    output logic                                          resp_hit,
    output logic [C_N_WAY-1:0]                            resp_way,
    output logic                                          resp_evict,
    output logic [TAG_ADDR_WDTH-1:0]                      resp_evict_tag,
    output logic [31:0]                                   hit_count,
    output logic [31:0]                                   miss_count
);

    localparam int BANK_W   = SET_ADDR_WDTH - C_LG_BANKS;
    localparam int WAYS     = 1 << C_N_WAY;
    localparam int NUM_SETS = 1 << BANK_W;

    state_t                     state;
    logic [BANK_W-1:0]          set_q;
    logic [TAG_ADDR_WDTH-1:0]   tag_q;
    logic [C_N_WAY-1:0]         rr_ptr [NUM_SETS];

    logic [WAYS-1:0]            match_vec;
    logic                       hit;
    logic [C_N_WAY-1:0]         hit_way;
    logic [C_N_WAY-1:0]         victim_way;
    logic                       evict;

    assign req_ready  = (state == IDLE);
    assign tag_r_addr = (state == IDLE) ? req_set : set_q;

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < WAYS; i++) begin
            match_vec[i] = tag_valid_bits[i] &&
                           (tag_slice(tag_r_data, C_N_WAY'(i)) == tag_q);
        end
    end

    way_select #(
        .N_WAY_LG (C_N_WAY)
    ) u_way_select (
        .valid_bits (tag_valid_bits),
        .match_vec  (match_vec),
        .rr_ptr     (rr_ptr[set_q]),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way),
        .evict      (evict)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            set_q          <= '0;
            tag_q          <= '0;
            tag_w_en       <= 1'b0;
            tag_w_addr     <= '0;
            tag_w_data     <= '0;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= '0;
            resp_evict     <= 1'b0;
            resp_evict_tag <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else begin
            tag_w_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        set_q <= req_set;
                        tag_q <= req_tag;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    resp_valid <= 1'b1;
                    resp_hit   <= hit;
                    if (hit) begin
                        resp_way       <= hit_way;
                        resp_evict     <= 1'b0;
                        resp_evict_tag <= '0;
                        if (hit_count != '1) begin
                            hit_count <= hit_count + 32'd1;
                        end
                    end else begin
                        resp_way       <= victim_way;
                        resp_evict     <= evict;
                        resp_evict_tag <= evict ? tag_slice(tag_r_data, victim_way) : '0;
                        tag_w_en       <= 1'b1;
                        tag_w_addr     <= {set_q, victim_way};
                        tag_w_data     <= tag_q;
                        if (miss_count != '1) begin
                            miss_count <= miss_count + 32'd1;
                        end
                        // The pointer only advances when a valid line is displaced.
                        if (evict) begin
                            rr_ptr[set_q] <= rr_ptr[set_q] + 1'b1;
                        end
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
